// File: rtl/i2s_master_tx.sv
// i2s_master_tx: I2S clock master and serial transmitter on MCLK; define I2S_TX_UNDERRUN_MUTE_EN to send silence instead of repeating on underrun
module i2s_master_tx #(
  parameter int RESOLUTION = 32,
  parameter int SCLK_DIV   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [RESOLUTION-1:0] data_in_L,
  input  logic [RESOLUTION-1:0] data_in_R,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  SCLK,
  output logic                  LRCK,
  output logic                  SDATA,
  output logic                  underrun
);
  localparam int FW = 2 * RESOLUTION;
  localparam int DW = $clog2(SCLK_DIV);
  localparam int BW = $clog2(FW);
  typedef enum logic {IDLE, RUN} state_t;
  state_t                r_state, w_next;
  logic [DW-1:0]         r_div_cnt;
  logic [BW-1:0]         r_bit_cnt, w_bit_nxt;
  logic [RESOLUTION-1:0] r_hold_L, r_hold_R;
  logic [FW-1:0]         r_shift, r_last, w_frame;
  logic                  r_hold_full, r_delay, r_lrck, r_sdata, r_underrun;
  logic                  w_fe, w_wrap, w_load, w_accept;
  assign w_fe      = (r_state == RUN) && (r_div_cnt == DW'(SCLK_DIV - 1));
  assign w_wrap    = w_fe && (r_bit_cnt == BW'(FW - 1));
  assign w_bit_nxt = w_wrap ? '0 : r_bit_cnt + 1'b1;
  assign w_load    = enable && ((r_state == IDLE) || w_wrap);
  assign w_accept  = in_valid && !r_hold_full;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
  assign w_frame   = r_hold_full ? {r_hold_L, r_hold_R} : '0;
`else
  assign w_frame   = r_hold_full ? {r_hold_L, r_hold_R} : r_last;
`endif
  assign in_ready  = !r_hold_full;
  assign SCLK      = r_div_cnt >= DW'(SCLK_DIV / 2);
  assign LRCK      = r_lrck;
  assign SDATA     = r_sdata;
  assign underrun  = r_underrun;
  // State register
  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  // Start on enable; stop only when a frame wraps with enable low
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE) w_next = enable ? RUN : IDLE;
    else if (w_wrap && !enable) w_next = IDLE;
  end
  // Holding register, frame load, serialiser and bit clock counters
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_div_cnt   <= '0;
      r_bit_cnt   <= '0;
      r_hold_L    <= '0;
      r_hold_R    <= '0;
      r_hold_full <= 1'b0;
      r_shift     <= '0;
      r_last      <= '0;
      r_delay     <= 1'b0;
      r_lrck      <= 1'b0;
      r_sdata     <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_hold_full <= w_accept | (r_hold_full & ~w_load);
      if (w_accept) begin
        r_hold_L <= data_in_L;
        r_hold_R <= data_in_R;
      end
      r_underrun <= w_load & ~r_hold_full;
      if (w_load) begin
        r_last  <= w_frame;
        r_delay <= w_frame[FW-1];
        r_shift <= w_frame << 1;
      end else if (w_fe) begin
        r_delay <= r_shift[FW-1];
        r_shift <= r_shift << 1;
      end
      if (w_next == IDLE) begin
        r_div_cnt <= '0;
        r_bit_cnt <= '0;
        r_lrck    <= 1'b0;
        r_sdata   <= 1'b0;
      end else if (r_state == RUN) begin
        r_div_cnt <= w_fe ? '0 : r_div_cnt + 1'b1;
        if (w_fe) begin
          r_bit_cnt <= w_bit_nxt;
          r_lrck    <= w_bit_nxt >= BW'(RESOLUTION);
          r_sdata   <= r_delay;
        end
      end
    end
  end
endmodule

// File: tb/tb_i2s_master_tx.sv
// tb_i2s_master_tx: scoreboard bench for i2s_master_tx; expected serial bits queued by stimulus, checked by a bus monitor
module tb_i2s_master_tx;
  localparam int RES = 32;
  localparam int DIV = 8;
  logic           clk = 0, reset = 0, enable = 0, in_valid = 0;
  logic [RES-1:0] data_in_L = '0, data_in_R = '0;
  logic           in_ready, SCLK, LRCK, SDATA, underrun;
  int             total = 0, bad = 0, ucnt = 0, slot = 0, frames = 0;
  logic           q[$];

  i2s_master_tx #(.RESOLUTION(RES), .SCLK_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .data_in_L(data_in_L), .data_in_R(data_in_R), .in_valid(in_valid),
    .in_ready(in_ready), .SCLK(SCLK), .LRCK(LRCK), .SDATA(SDATA), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [RES-1:0] l, input logic [RES-1:0] r);
    logic [2*RES-1:0] v;
    v = {l, r};
    for (int i = 2*RES-1; i >= 0; i--) q.push_back(v[i]);
  endtask

  task automatic send(input logic [RES-1:0] l, input logic [RES-1:0] r);
    int n;
    n = 0;
    @(negedge clk);
    data_in_L = l;
    data_in_R = r;
    in_valid  = 1;
    while (!in_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic wait_fs(input int f, input int s);
    int n;
    n = 0;
    while (!(frames == f && slot == s) && n < 20000) begin
      @(negedge clk);
      n++;
    end
    chk("wait_slot", (frames == f && slot == s), 1);
  endtask

  // Bus monitor: tracks slots from SCLK falls, checks timing, pops expected bits
  initial begin : mon
    logic ps = 0, plr = 0, pu = 0, pend = 0, pact = 0, pexp = 0;
    int idle = 0, cyc = 0, lf = -1, lr = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (underrun && !pu) ucnt++;
      if (pu) chk("underrun_width", underrun, 0);
      idle = (SCLK == ps) ? idle + 1 : 0;
      if (idle > 2*DIV) begin
        slot = 0;
        pend = 0;
        lf   = -1;
        lr   = -1;
      end
      if (!plr && LRCK) begin
        if (lr >= 0) chk("lrck_period", cyc - lr, 2*RES*DIV);
        lr = cyc;
      end
      if (ps && !SCLK) begin
        if (lf >= 0) chk("sclk_period", cyc - lf, DIV);
        lf = cyc;
        slot = (slot + 1) % (2*RES);
        if (slot == 0) frames++;
        chk("lrck_slot", LRCK, slot >= RES);
        if (pend) begin
          chk("sdata_slot0", pact, pexp);
          pend = 0;
        end
        chk("sb_nonempty", q.size() != 0, 1);
        if (q.size() != 0) begin
          if (slot == 0) begin
            pexp = q.pop_front();
            pact = SDATA;
            pend = 1;
          end else chk("sdata", SDATA, q.pop_front());
        end
      end
      ps  = SCLK;
      plr = LRCK;
      pu  = underrun;
    end
  end

  initial begin
    int n;
    repeat (5) @(negedge clk);
    chk("rst_sclk", SCLK, 0);
    chk("rst_lrck", LRCK, 0);
    chk("rst_sdata", SDATA, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_underrun", underrun, 0);
    reset = 1;
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if ({SCLK, LRCK, SDATA, in_ready, underrun} !== 5'b00010) n++;
    end
    chk("idle_static", n, 0);
    send(32'hA5A5_0001, 32'h8000_00FF);
    chk("hold_full", in_ready, 0);
    push_frame(32'hA5A5_0001, 32'h8000_00FF);
    enable   = 1;
    in_valid = 1;
    for (int k = 1; k <= 4; k++) begin
      data_in_L = 32'h5A5A_0000 + k;
      data_in_R = 32'h0000_A5A0 + k;
      n = 0;
      while (!in_ready && n < 2000) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_ready", in_ready, 1);
      push_frame(data_in_L, data_in_R);
      @(negedge clk);
    end
    in_valid = 0;
`ifdef I2S_TX_UNDERRUN_MUTE_EN
    push_frame('0, '0);
`else
    push_frame(32'h5A5A_0004, 32'h0000_A5A4);
`endif
    wait_fs(4, 1);
    chk("no_underrun_b2b", ucnt, 0);
    wait_fs(5, 1);
    chk("underrun_once", ucnt, 1);
    send(32'h0123_4567, 32'h89AB_CDEF);
    push_frame(32'h0123_4567, 32'h89AB_CDEF);
    wait_fs(6, 10);
    send(32'hFEDC_BA98, 32'h7654_3210);
    enable = 0;
    wait_fs(7, 0);
    repeat (20) @(negedge clk);
    chk("dis_sclk", SCLK, 0);
    chk("dis_lrck", LRCK, 0);
    chk("dis_sdata", SDATA, 0);
    chk("dis_hold_kept", in_ready, 0);
    chk("dis_underrun_total", ucnt, 1);
    push_frame(32'hFEDC_BA98, 32'h7654_3210);
    enable = 1;
    wait_fs(7, 40);
    reset  = 0;
    enable = 0;
    @(negedge clk);
    chk("mrst_sclk", SCLK, 0);
    chk("mrst_lrck", LRCK, 0);
    chk("mrst_sdata", SDATA, 0);
    chk("mrst_in_ready", in_ready, 1);
    chk("mrst_underrun", underrun, 0);
    reset = 1;
    repeat (20) @(negedge clk);
    q.delete();
    send(32'h0F1E_2D3C, 32'h4B5A_6978);
    push_frame(32'h0F1E_2D3C, 32'h4B5A_6978);
    enable = 1;
    wait_fs(7, 2);
    enable = 0;
    wait_fs(8, 0);
    repeat (20) @(negedge clk);
    chk("sb_drained", q.size(), 0);
    chk("underrun_final", ucnt, 1);
    chk("end_sclk", SCLK, 0);
    chk("end_in_ready", in_ready, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2s_master_tx.md
Name: i2s_master_tx

Overview:
- I2S transmitter and clock master for the DAC side of the audio path, running on MCLK.
- Generates SCLK and LRCK itself by dividing MCLK.
- Accepts stereo sample pairs from the effects chain through a valid/ready handshake and a one-deep holding register.
- Serialises each pair MSB-first in standard I2S framing, with a one-SCLK data delay after each LRCK edge.

Parameters:
- RESOLUTION, 32, bits per channel slot; a frame is 2*RESOLUTION SCLK periods.
- SCLK_DIV, 8, MCLK cycles per SCLK period; even, >= 2.

Ports:
- clk  in  1  MCLK, the only clock; everything is posedge clk.
- reset  in  1  synchronous, active-low reset.
- enable  in  1  run request; sampled at frame boundaries.
- data_in_L  in  RESOLUTION  left sample, two's complement.
- data_in_R  in  RESOLUTION  right sample, two's complement.
- in_valid  in  1  data_in_L/R valid.
- in_ready  out  1  holding register empty.
- SCLK  out  1  serial bit clock.
- LRCK  out  1  word select; 0 = left, 1 = right.
- SDATA  out  1  serial data; changes only on SCLK falling edges.
- underrun  out  1  one-clk pulse when a frame starts with no new sample.

Behaviour:
- Reset, applied while reset==0 at posedge:
  - SCLK=0, LRCK=0, SDATA=0, in_ready=1, underrun=0.
  - div_cnt=0, bit_cnt=0, holding empty, shift/last registers 0, state IDLE.
  - Reset mid-frame aborts the frame immediately with no completion and discards the holding register.
- States:
  - IDLE: SCLK/LRCK/SDATA held 0, counters 0. The handshake stays live, so the holding register may fill.
  - IDLE -> RUN: on the clk where enable==1. That same clk performs a frame load (below) with bit_cnt=0.
  - RUN: div_cnt counts 0..SCLK_DIV-1 and wraps.
  - RUN -> IDLE: only at a frame boundary (bit_cnt wrapping 2*RESOLUTION-1 -> 0) with enable==0. No partial frames; no load occurs on that boundary.
- Clocking in RUN:
  - SCLK = 0 while div_cnt < SCLK_DIV/2, else 1.
  - A falling edge (fe) is the clk where div_cnt wraps to 0. On fe, bit_cnt increments mod 2*RESOLUTION.
  - LRCK = (bit_cnt >= RESOLUTION), registered so it changes on fe.
- Frame load, on the fe where bit_cnt becomes 0, and on RUN entry:
  - Holding full: shift <= {hold_L, hold_R}; last <= {hold_L, hold_R}; holding emptied.
  - Holding empty: shift <= last (repeat); underrun=1 for exactly that clk.
- Serialisation:
  - On each fe, delay_bit <= shift[MSB], shift <<= 1, SDATA <= delay_bit.
  - Result: left MSB appears on the fe one SCLK after LRCK falls, and right MSB one SCLK after LRCK rises.
  - The last right LSB is output in bit slot 0 of the following frame.
- Handshake:
  - Accept when in_valid && in_ready at posedge. in_ready falls the next clk.
  - in_ready rises the clk after a load empties the holding register.
  - Data must not change while in_valid && !in_ready. Dropped samples are impossible by construction.
- Simultaneous load and in_valid with holding empty:
  - Counts as underrun; the frame repeats last.
  - The accept in the same clk fills the holding register for the next frame.
- Throughput: at most one pair per 2*RESOLUTION*SCLK_DIV clks (512 with defaults).
- No arithmetic on sample values; widths are fixed at RESOLUTION and there is no truncation.

Optional Feature:
- Macro I2S_TX_UNDERRUN_MUTE_EN.
- Defined: an underrun frame loads all-zero samples, and last is also cleared to 0.
- Undefined: an underrun frame repeats the previous pair, as described in Behaviour.
- The underrun pulse behaves identically in both builds.

Test Plan:
- Reset and idle: hold reset=0 5 clks with enable=0 -> SCLK=LRCK=SDATA=0, in_ready=1, underrun=0. Outputs stay static for 100 clks after release.
- Single frame: preload L=32'hA5A5_0001, R=32'h8000_00FF, then enable=1 (defaults) -> SCLK period 8 clks, LRCK period 512 clks.
  - SDATA at LRCK-fall slots 1..32 reads A5A50001 MSB-first; slots 33..64 read 800000FF.
  - LRCK rises on the 32nd fe after start.
- Back-to-back: in_valid held 1 with incrementing pairs over 4 frames -> one accept per frame, no underrun, each frame's data exact.
- Underrun: no new sample before frame 2 -> underrun pulses exactly 1 clk at the frame-2 load.
  - Frame 2 repeats frame 1 data; with I2S_TX_UNDERRUN_MUTE_EN it is all zeros.
- Disable mid-frame: enable=0 at bit_cnt=10 -> the frame completes all 64 slots, then SCLK/LRCK go 0 and the held sample is kept. Re-enabling sends it.
- Reset mid-frame: reset=0 at bit_cnt=40 for 1 clk -> next clk all outputs are at reset values and in_ready=1. A new frame starts cleanly on enable.
